// File: rtl/counter_16.sv
`default_nettype none
// ============================================================================
// Module   : counter_16
// Purpose  : Event counter advanced by each rising edge of a slow,
//            asynchronous increment strobe (e.g. a debounced pushbutton).
//            The strobe is synchronised into the clk domain, edge detected,
//            and each detected edge adds one to the count.
// Ports    : clk      - system clock, all state updates on its rising edge
//            reset_n  - synchronous reset, ACTIVE HIGH (1 = reset)
//            inc      - asynchronous increment strobe (level)
//            count    - registered count value, WIDTH bits
//            wrap     - registered one-cycle pulse on all-ones -> 0 rollover
// Revision : 1.0 - initial release
// ============================================================================
module counter_16 #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,   // synchroniser depth, must be >= 2
  parameter int SATURATE    = 0    // 0 = wrap at all-ones, 1 = hold at all-ones
) (
  input  logic             clk,
  input  logic             reset_n,  // active HIGH despite the suffix
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic [WIDTH-1:0]       count_q;
  logic [WIDTH-1:0]       count_d;
  logic                   wrap_q;
  logic                   wrap_d;
  logic                   pulse;
  logic [WIDTH-1:0]       ovf_count;
  logic                   ovf_wrap;

  // Shift chain: inc enters at bit 0, the settled value leaves at the top.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], inc};
  assign prev_d = sync_q[SYNC_STAGES-1];

  // One-cycle pulse on a low-to-high transition of the synchronised strobe.
  assign pulse  = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Result of an increment taken at all-ones, chosen at elaboration time.
  generate
    if (SATURATE != 0) begin : g_saturate
      assign ovf_count = c_ALL_ONES;
      assign ovf_wrap  = 1'b0;
    end else begin : g_wrap
      assign ovf_count = '0;
      assign ovf_wrap  = 1'b1;
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (pulse) begin
      if (count_q == c_ALL_ONES) begin
        count_d = ovf_count;
        wrap_d  = ovf_wrap;
      end else begin
        count_d = count_q + c_ONE;
      end
    end
  end

  // Reset also clears the synchroniser and edge history, so any edge in
  // flight is discarded and a strobe held high through release counts once.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_16
// Purpose  : Self-checking bench for counter_16. A 16-bit wrapping instance
//            plus 4-bit wrapping and saturating instances share one stimulus;
//            a behavioural model tracks all three.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_16;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inc;
  logic [15:0] count;
  logic        wrap;
  logic [3:0]  count_w4;
  logic        wrap_w4;
  logic [3:0]  count_s4;
  logic        wrap_s4;

  always #5 clk = ~clk;  // 100 MHz

  counter_16 #(.WIDTH(16), .SYNC_STAGES(SYNC), .SATURATE(0)) dut (
    .clk(clk), .reset_n(reset_n), .inc(inc), .count(count), .wrap(wrap));

  counter_16 #(.WIDTH(4), .SYNC_STAGES(SYNC), .SATURATE(0)) dut_w4 (
    .clk(clk), .reset_n(reset_n), .inc(inc), .count(count_w4), .wrap(wrap_w4));

  counter_16 #(.WIDTH(4), .SYNC_STAGES(SYNC), .SATURATE(1)) dut_s4 (
    .clk(clk), .reset_n(reset_n), .inc(inc), .count(count_s4), .wrap(wrap_s4));

  typedef struct {
    bit          rst;
    bit          inc;
    logic [15:0] exp_count;
    bit          exp_wrap;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int errors = 0;

  // Behavioural model: inc samples taken since the last reset (reset history
  // reads as zero). An increment lands SYNC edges after the first high sample
  // that follows a low sample.
  bit hist[$];
  int m16, m4w, m4s;
  bit mw16, mw4w;
  int wrap_seen_w4, wrap_seen_s4;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit i);
    bit ev;
    mw16 = 1'b0;
    mw4w = 1'b0;
    if (r) begin
      hist.delete();
      repeat (SYNC + 1) hist.push_back(1'b0);
      m16 = 0;
      m4w = 0;
      m4s = 0;
      return;
    end
    hist.push_back(i);
    ev = hist[hist.size() - 1 - SYNC] && !hist[hist.size() - 2 - SYNC];
    while (hist.size() > SYNC + 1) void'(hist.pop_front());
    if (ev) begin
      m16 = (m16 + 1) % 65536;
      if (m16 == 0) mw16 = 1'b1;
      m4w = (m4w + 1) % 16;
      if (m4w == 0) mw4w = 1'b1;
      if (m4s < 15) m4s = m4s + 1;
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, compare all instances 1 ns later.
  task automatic step(input bit r, input bit i);
    @(negedge clk);
    reset_n = r;
    inc     = i;
    @(posedge clk);
    model_edge(r, i);
    #1;
    check("count16", int'(count), m16);
    check("wrap16", int'(wrap), int'(mw16));
    check("count_w4", int'(count_w4), m4w);
    check("wrap_w4", int'(wrap_w4), int'(mw4w));
    check("count_s4", int'(count_s4), m4s);
    check("wrap_s4", int'(wrap_s4), 0);
    if (wrap_w4) wrap_seen_w4++;
    if (wrap_s4) wrap_seen_s4++;
  endtask

  initial begin
    bit iv;
    reset_n = 1'b1;
    inc     = 1'b0;
    repeat (SYNC + 1) hist.push_back(1'b0);
    m16 = 0; m4w = 0; m4s = 0; mw16 = 0; mw4w = 0;
    wrap_seen_w4 = 0;
    wrap_seen_s4 = 0;

    // Directed table for the 16-bit instance; expectations after each edge.
    // Reset with inc toggling, then release.
    tbl.push_back('{1'b1, 1'b0, 16'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'd0, 1'b0});
    // First high sample at edge 4, count moves at edge 6, held level counts once.
    tbl.push_back('{1'b0, 1'b1, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'd1, 1'b0});
    // Minimum period input: high samples at 9 and 11 count at 11 and 13.
    tbl.push_back('{1'b0, 1'b0, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'd3, 1'b0});
    // Reset lands on the edge the pending increment would have taken.
    tbl.push_back('{1'b0, 1'b1, 16'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'd3, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'd0, 1'b0});
    // inc held high through reset release: counted once, two edges later.
    tbl.push_back('{1'b1, 1'b1, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'd1, 1'b0});

    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].rst, tbl[n].inc);
      check($sformatf("tbl%0d_count", n), int'(count), int'(tbl[n].exp_count));
      check($sformatf("tbl%0d_wrap", n), int'(wrap), int'(tbl[n].exp_wrap));
    end

    // Single edge held for 20 cycles: exactly one increment at k+2.
    repeat (3) step(1'b0, 1'b0);
    check("single_pre", int'(count), 1);
    step(1'b0, 1'b1);
    check("single_k", int'(count), 1);
    step(1'b0, 1'b1);
    check("single_k1", int'(count), 1);
    step(1'b0, 1'b1);
    check("single_k2", int'(count), 2);
    repeat (17) step(1'b0, 1'b1);
    check("single_hold", int'(count), 2);

    // Toggle every clock for 40 cycles: 20 rising edges, 20 increments.
    for (int i = 0; i < 40; i++) step(1'b0, (i % 2) == 1);
    repeat (2) step(1'b0, 1'b0);
    check("toggle_total", int'(count), 22);

    // Rollover on the 4-bit instances: 15 edges to all-ones, then one more.
    step(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, (i % 2) == 1);
    repeat (2) step(1'b0, 1'b0);
    check("w4_full", int'(count_w4), 15);
    check("s4_full", int'(count_s4), 15);
    wrap_seen_w4 = 0;
    wrap_seen_s4 = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("w4_rolled", int'(count_w4), 0);
    check("w4_wrap_pulse", int'(wrap_w4), 1);
    check("s4_held", int'(count_s4), 15);
    check("c16_after16", int'(count), 16);
    step(1'b0, 1'b0);
    check("w4_wrap_drop", int'(wrap_w4), 0);
    repeat (4) step(1'b0, 1'b0);
    check("w4_wrap_once", wrap_seen_w4, 1);
    check("s4_wrap_never", wrap_seen_s4, 0);

    // Randomised run against the model, with occasional resets.
    iv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) iv = ~iv;
      step($urandom_range(0, 149) == 0, iv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
